// File: rtl/bcd_calc_pkg.sv
// Shared types and constants for the digit-serial BCD add/subtract calculator.
package bcd_calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic       OP_ADD   = 1'b0;
    localparam logic       OP_SUB   = 1'b1;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage : bcd_calc_pkg

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: {cout, sum} = a + b + cin with decimal correction.
module bcd_digit_add
    import bcd_calc_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] bin_sum;

    always_comb begin
        bin_sum = 5'(a) + 5'(b) + 5'(cin);
        if (bin_sum > 5'(BCD_MAX)) begin
            sum  = 4'(bin_sum + 5'(BCD_CORR));
            cout = 1'b1;
        end else begin
            sum  = bin_sum[3:0];
            cout = 1'b0;
        end
    end

endmodule : bcd_digit_add

// File: rtl/bcd_seq_calc.sv
// Digit-serial BCD add/subtract controller sharing one bcd_digit_add over all digits.
// Optional build macro BCD_CALC_SAT_EN saturates the result on ovf (all 9s) / unf (all 0s).
module bcd_seq_calc
    import bcd_calc_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  ovf,
    output logic                  unf,
    output logic                  invalid
);

    localparam int unsigned W        = 4 * DIGITS;
    localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               invalid_q, invalid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               bad_c;
    logic [3:0]         a_dig_c;
    logic [3:0]         b_dig_c;
    logic [3:0]         addend_c;
    logic [3:0]         sum_c;
    logic               cout_c;

    // Validity is judged on the latched operands during the first RUN cycle.
    always_comb begin
        bad_c = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((a_q[4*i +: 4] > BCD_MAX) || (b_q[4*i +: 4] > BCD_MAX)) begin
                bad_c = 1'b1;
            end
        end
    end

    always_comb begin
        a_dig_c  = a_q[{idx_q, 2'b00} +: 4];
        b_dig_c  = b_q[{idx_q, 2'b00} +: 4];
        addend_c = (op_q == OP_SUB) ? (BCD_MAX - b_dig_c) : b_dig_c;
    end

    bcd_digit_add u_digit_add (
        .a    (a_dig_c),
        .b    (addend_c),
        .cin  (carry_q),
        .sum  (sum_c),
        .cout (cout_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (bad_c || (idx_q == LAST_IDX)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        invalid_d = invalid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a_bcd;
                    b_d       = b_bcd;
                    op_d      = op;
                    idx_d     = '0;
                    carry_d   = op;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                    invalid_d = 1'b0;
                end
            end
            RUN: begin
                if (bad_c) begin
                    invalid_d = 1'b1;
                    result_d  = '0;
                end else begin
                    result_d[{idx_q, 2'b00} +: 4] = sum_c;
                    carry_d = cout_c;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        if (op_q == OP_ADD) begin
                            ovf_d = cout_c;
                        end else begin
                            unf_d = ~cout_c;
                        end
`ifdef BCD_CALC_SAT_EN
                        if ((op_q == OP_ADD) && cout_c) begin
                            result_d = {DIGITS{BCD_MAX}};
                        end
                        if ((op_q == OP_SUB) && !cout_c) begin
                            result_d = '0;
                        end
`endif
                    end
                end
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign invalid = invalid_q;

endmodule : bcd_seq_calc

// File: tb/tb_bcd_seq_calc.sv
// Self-checking bench for bcd_seq_calc (DIGITS=2): vector table, random ops vs. a decimal model, corner sequences.
module tb_bcd_seq_calc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [7:0] a_bcd;
    logic [7:0] b_bcd;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       ovf;
    logic       unf;
    logic       invalid;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       ovf;
        logic       unf;
        logic       inv;
        int         lat;
    } vec_t;

    vec_t sb[$];

    bcd_seq_calc #(.DIGITS(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a_bcd   (a_bcd),
        .b_bcd   (b_bcd),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .unf     (unf),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

`ifdef BCD_CALC_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic o, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] r, input logic v, input logic u, input logic i);
        vec_t t;
        t.op = o; t.a = a; t.b = b; t.res = r; t.ovf = v; t.unf = u; t.inv = i;
        t.lat = i ? 1 : 2;
        return t;
    endfunction

    // Decimal reference: integer arithmetic modulo 100.
    function automatic vec_t model(input logic o, input logic [7:0] a, input logic [7:0] b);
        int av, bv, r;
        logic v, u, i;
        i  = (a[7:4] > 9) || (a[3:0] > 9) || (b[7:4] > 9) || (b[3:0] > 9);
        av = int'(a[7:4]) * 10 + int'(a[3:0]);
        bv = int'(b[7:4]) * 10 + int'(b[3:0]);
        v = 1'b0; u = 1'b0; r = 0;
        if (!i) begin
            if (!o) begin
                r = av + bv;
                v = (r > 99);
                r = r % 100;
                if (SAT && v) r = 99;
            end else begin
                r = av - bv;
                u = (r < 0);
                r = (r + 100) % 100;
                if (SAT && u) r = 0;
            end
        end
        return mk(o, a, b, {4'(r / 10), 4'(r % 10)}, v, u, i);
    endfunction

    task automatic do_op(input vec_t e, input string tag, input bit hold_start);
        vec_t got;
        int   cyc;
        @(negedge clk);
        start = 1'b1; op = e.op; a_bcd = e.a; b_bcd = e.b;
        sb.push_back(e);
        @(negedge clk);
        if (hold_start) begin
            op = ~e.op; a_bcd = 8'h99; b_bcd = 8'h98;
        end else begin
            start = 1'b0; a_bcd = 8'h77; b_bcd = 8'h66;
        end
        chk({tag, " busy"}, int'(busy), 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, e.lat);
        got = sb.pop_front();
        chk({tag, " result"}, int'(result), int'(got.res));
        chk({tag, " ovf"}, int'(ovf), int'(got.ovf));
        chk({tag, " unf"}, int'(unf), int'(got.unf));
        chk({tag, " invalid"}, int'(invalid), int'(got.inv));
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done pulse"}, int'(done), 0);
        chk({tag, " busy drop"}, int'(busy), 0);
        chk({tag, " result hold"}, int'(result), int'(got.res));
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = mk(1'b0, 8'h45, 8'h37, 8'h82, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 8'h99, 8'h01, SAT ? 8'h99 : 8'h00, 1'b1, 1'b0, 1'b0);
        tbl[2] = mk(1'b0, 8'h3A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        tbl[3] = mk(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
        tbl[4] = mk(1'b1, 8'h52, 8'h17, 8'h35, 1'b0, 1'b0, 1'b0);
        tbl[5] = mk(1'b1, 8'h40, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[6] = mk(1'b1, 8'h17, 8'h52, SAT ? 8'h00 : 8'h65, 1'b0, 1'b1, 1'b0);
        tbl[7] = mk(1'b1, 8'h00, 8'h01, SAT ? 8'h00 : 8'h99, 1'b0, 1'b1, 1'b0);
        tbl[8] = mk(1'b1, 8'h05, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1);
        tbl[9] = mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; start = 1'b0; op = 1'b0; a_bcd = '0; b_bcd = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset result", int'(result), 0);
        chk("reset flags", int'({ovf, unf, invalid}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i], $sformatf("vec%0d", i), 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra, rb;
            ra = {4'($urandom_range(9)), 4'($urandom_range(9))};
            rb = {4'($urandom_range(9)), 4'($urandom_range(9))};
            do_op(model(1'($urandom_range(1)), ra, rb), $sformatf("rnd%0d", i), 1'b0);
        end

        // start held high through RUN and DONE with other operands must not disturb the op.
        do_op(mk(1'b0, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0), "start_in_run", 1'b1);

        // Asynchronous reset mid-operation, then a clean operation.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_bcd = 8'h45; b_bcd = 8'h37;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun reset busy", int'(busy), 0);
        chk("midrun reset done", int'(done), 0);
        chk("midrun reset result", int'(result), 0);
        chk("midrun reset flags", int'({ovf, unf, invalid}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(mk(1'b0, 8'h20, 8'h05, 8'h25, 1'b0, 1'b0, 1'b0), "after_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bcd_seq_calc
